// File: rtl/query_enumerator_pkg.sv
// Shared definitions for the query enumerator: atom codes, default sizes and FSM states.
package query_enumerator_pkg;

    localparam int ATOM_BITS_DEF  = 3;
    localparam int NUM_ATOMS_DEF  = 6;
    localparam int FIFO_DEPTH_DEF = 4;

    // Atom codes of the friends/2 program; only codes below NUM_ATOMS are ever swept.
    localparam logic [ATOM_BITS_DEF-1:0] ATOM_ALICE = 3'd0;
    localparam logic [ATOM_BITS_DEF-1:0] ATOM_BOB   = 3'd1;
    localparam logic [ATOM_BITS_DEF-1:0] ATOM_CAROL = 3'd2;
    localparam logic [ATOM_BITS_DEF-1:0] ATOM_DAVE  = 3'd3;
    localparam logic [ATOM_BITS_DEF-1:0] ATOM_LIKES = 3'd4;
    localparam logic [ATOM_BITS_DEF-1:0] ATOM_HATES = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/query_enumerator_sol_fifo.sv
// First-word-fall-through solution FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sol_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = din;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/query_enumerator.sv
// Sweeps every (P1,P2) atom pair through an external combinational predicate and
// streams the satisfying pairs, in scan order, through a small FIFO with a count.
module query_enumerator
    import query_enumerator_pkg::*;
#(
    parameter  int ATOM_BITS  = ATOM_BITS_DEF,
    parameter  int NUM_ATOMS  = NUM_ATOMS_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int COUNT_W    = $clog2(NUM_ATOMS*NUM_ATOMS+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ATOM_BITS-1:0] pred_p1,
    output logic [ATOM_BITS-1:0] pred_p2,
    input  logic                 pred_valid,
    output logic                 sol_valid,
    input  logic                 sol_ready,
    output logic [ATOM_BITS-1:0] sol_p1,
    output logic [ATOM_BITS-1:0] sol_p2,
    output logic [COUNT_W-1:0]   sol_count
);
    localparam logic [ATOM_BITS-1:0] LAST_ATOM = ATOM_BITS'(NUM_ATOMS-1);
    localparam logic [ATOM_BITS-1:0] ATOM_ONE  = ATOM_BITS'(1);
    localparam logic [COUNT_W-1:0]   COUNT_ONE = COUNT_W'(1);

    state_t                 state_q, state_d;
    logic [ATOM_BITS-1:0]   p1_q, p1_d;
    logic [ATOM_BITS-1:0]   p2_q, p2_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty, advance;
    logic [2*ATOM_BITS-1:0] fifo_head;

    assign fifo_pop  = sol_ready && !fifo_empty;
    assign sol_valid = !fifo_empty;
    assign sol_p1    = fifo_head[2*ATOM_BITS-1:ATOM_BITS];
    assign sol_p2    = fifo_head[ATOM_BITS-1:0];
    assign pred_p1   = p1_q;
    assign pred_p2   = p2_q;
    assign sol_count = count_q;
    assign busy      = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        count_d   = count_q;
        fifo_push = 1'b0;
        advance   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    p1_d    = '0;
                    p2_d    = '0;
                    count_d = '0;
                end
            end
            S_SCAN: begin
                // A full FIFO still takes the pair when the head leaves in the same cycle.
                fifo_push = pred_valid && (!fifo_full || fifo_pop);
                advance   = !pred_valid || fifo_push;
                if (fifo_push) begin
                    count_d = count_q + COUNT_ONE;
                end
                if (advance) begin
                    if (p2_q == LAST_ATOM) begin
                        p2_d = '0;
                        if (p1_q == LAST_ATOM) begin
                            p1_d    = '0;
                            state_d = S_DRAIN;
                        end else begin
                            p1_d = p1_q + ATOM_ONE;
                        end
                    end else begin
                        p2_d = p2_q + ATOM_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            count_q <= count_d;
        end
    end

    sol_fifo #(
        .WIDTH (2*ATOM_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_sol_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({p1_q, p2_q}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_head)
    );

endmodule

// File: tb/tb_query_enumerator.sv
// Randomised bench for query_enumerator: a table-driven predicate plus a list-based
// reference model of the expected solution stream, scan order and timing.
module tb_query_enumerator;
    localparam int NA    = 6;
    localparam int AB    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 6;

    typedef logic [5:0] pq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sol_ready = 1'b0;
    logic          pred_valid;
    logic          busy, done, sol_valid;
    logic [AB-1:0] pred_p1, pred_p2, sol_p1, sol_p2;
    logic [CW-1:0] sol_count;

    bit tab [NA*NA];

    always #5 clk = ~clk;

    always_comb begin
        pred_valid = 1'b0;
        if (int'(pred_p1) < NA && int'(pred_p2) < NA)
            pred_valid = tab[int'(pred_p1)*NA + int'(pred_p2)];
    end

    query_enumerator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pred_p1    (pred_p1),
        .pred_p2    (pred_p2),
        .pred_valid (pred_valid),
        .sol_valid  (sol_valid),
        .sol_ready  (sol_ready),
        .sol_p1     (sol_p1),
        .sol_p2     (sol_p2),
        .sol_count  (sol_count)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    pq_t popped_q;
    pq_t pred_seq;
    int  done_cnt, done_n, cnt_first;
    int  snap_n = -1;
    int  occ_lo = 1;
    int  occ_hi = 0;
    bit  timed_out, sv_seen, hold_ok, code_ok, occ_ok;
    logic [5:0]    snap_pair, snap_head;
    logic [CW-1:0] snap_cnt;
    logic          snap_valid;

    // Reference: solutions are the true table entries visited P1-outer, P2-inner.
    function automatic pq_t exp_list();
        pq_t q;
        for (int a = 0; a < NA; a++)
            for (int b = 0; b < NA; b++)
                if (tab[a*NA+b]) q.push_back({3'(a), 3'(b)});
        return q;
    endfunction

    function automatic pq_t scan_order();
        pq_t q;
        for (int a = 0; a < NA; a++)
            for (int b = 0; b < NA; b++)
                q.push_back({3'(a), 3'(b)});
        q.push_back(6'd0);
        return q;
    endfunction

    function automatic pq_t dedup(input pq_t a);
        pq_t r;
        foreach (a[i])
            if (r.size() == 0 || r[r.size()-1] != a[i]) r.push_back(a[i]);
        return r;
    endfunction

    function automatic int first_diff(input pq_t a, input pq_t b);
        int m;
        m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++)
            if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return m;
        return -1;
    endfunction

    task automatic set_tab(input int pct);
        for (int i = 0; i < NA*NA; i++) tab[i] = (int'($urandom_range(99)) < pct);
    endtask

    task automatic set_friends();
        for (int i = 0; i < NA*NA; i++) tab[i] = 1'b0;
        tab[0*NA+2] = 1'b1;
        tab[2*NA+0] = 1'b1;
    endtask

    task automatic run_sweep(input int ready_pct, input bit hold_start, input int ready_zero);
        logic       pv, pr, rdy;
        logic [5:0] pp;
        int         n, end_n;
        popped_q.delete();
        pred_seq.delete();
        done_cnt = 0; done_n = 0; cnt_first = -1;
        timed_out = 0; sv_seen = 0; hold_ok = 1; code_ok = 1; occ_ok = 1;
        pv = 1'b0; pr = 1'b0; pp = '0; n = 0; end_n = 400;
        @(negedge clk);
        start = 1'b1;
        sol_ready = 1'b0;
        while (n < end_n) begin
            @(negedge clk);
            n++;
            if (!hold_start) start = 1'b0;
            if (n == 1) cnt_first = int'(sol_count);
            if (busy) pred_seq.push_back({pred_p1, pred_p2});
            if (int'(pred_p1) >= NA || int'(pred_p2) >= NA) code_ok = 0;
            if (sol_valid) sv_seen = 1;
            if (pv && !pr && (!sol_valid || {sol_p1, sol_p2} != pp)) hold_ok = 0;
            if (n >= occ_lo && n <= occ_hi && int'(sol_count) - popped_q.size() != DEPTH) occ_ok = 0;
            if (n == snap_n) begin
                snap_pair = {pred_p1, pred_p2};
                snap_head = {sol_p1, sol_p2};
                snap_cnt = sol_count;
                snap_valid = sol_valid;
            end
            if (done) begin
                done_cnt++;
                if (done_n == 0) begin
                    done_n = n;
                    end_n = n + 4;
                end
                start = 1'b0;
            end
            rdy = (n > ready_zero) && (int'($urandom_range(99)) < ready_pct);
            sol_ready = rdy;
            if (sol_valid && rdy) popped_q.push_back({sol_p1, sol_p2});
            pv = sol_valid; pr = rdy; pp = {sol_p1, sol_p2};
        end
        if (done_n == 0) timed_out = 1;
        start = 1'b0;
        sol_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, sol_valid, pred_p1, pred_p2, sol_p1, sol_p2, sol_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b pred=%0d,%0d sol=%0d,%0d cnt=%0d, want all 0",
                     busy, done, sol_valid, pred_p1, pred_p2, sol_p1, sol_p2, sol_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, sol_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b valid=%b, want 0 0 0", busy, done, sol_valid);
        end
    endtask

    task automatic test_friends();
        pq_t e, d;
        int  k;
        set_friends();
        run_sweep(100, 1'b0, 0);
        e = exp_list();
        k = first_diff(popped_q, e);
        n_cmp++;
        if (k != -1) begin
            n_bad++;
            $display("FAIL friends_list: diff at %0d, got %0d items want %0d", k, popped_q.size(), e.size());
        end
        n_cmp++;
        if (sol_count !== 6'd2) begin
            n_bad++;
            $display("FAIL friends_count: got %0d want 2", sol_count);
        end
        n_cmp++;
        if (done_cnt != 1 || done_n != 38) begin
            n_bad++;
            $display("FAIL friends_done: got %0d pulses at cycle %0d, want 1 at 38", done_cnt, done_n);
        end
        d = dedup(pred_seq);
        k = first_diff(d, scan_order());
        n_cmp++;
        if (k != -1 || pred_seq.size() != 37) begin
            n_bad++;
            $display("FAIL friends_scan: diff at %0d, busy cycles %0d want 37", k, pred_seq.size());
        end
        n_cmp++;
        if (!code_ok) begin
            n_bad++;
            $display("FAIL atom_range: got a driven code >= %0d, want none", NA);
        end
    endtask

    task automatic test_stall();
        pq_t e;
        int  k;
        for (int i = 0; i < NA*NA; i++) tab[i] = 1'b1;
        snap_n = 10;
        run_sweep(100, 1'b0, 12);
        snap_n = -1;
        n_cmp++;
        if (snap_pair !== {3'd0, 3'd4} || snap_cnt !== 6'd4) begin
            n_bad++;
            $display("FAIL stall_hold: got pair %0d,%0d cnt %0d, want 0,4 cnt 4",
                     snap_pair[5:3], snap_pair[2:0], snap_cnt);
        end
        n_cmp++;
        if (snap_valid !== 1'b1 || snap_head !== 6'd0) begin
            n_bad++;
            $display("FAIL stall_head: got valid=%b head %0d,%0d, want 1 0,0",
                     snap_valid, snap_head[5:3], snap_head[2:0]);
        end
        e = exp_list();
        k = first_diff(popped_q, e);
        n_cmp++;
        if (k != -1) begin
            n_bad++;
            $display("FAIL stall_list: diff at %0d, got %0d items want %0d", k, popped_q.size(), e.size());
        end
        n_cmp++;
        if (sol_count !== 6'd36 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL stall_count: got cnt %0d dones %0d, want 36 and 1", sol_count, done_cnt);
        end
        n_cmp++;
        if (!hold_ok) begin
            n_bad++;
            $display("FAIL stall_stable: got head changing while not ready, want stable");
        end
    endtask

    task automatic test_none();
        for (int i = 0; i < NA*NA; i++) tab[i] = 1'b0;
        run_sweep(50, 1'b0, 0);
        n_cmp++;
        if (sv_seen || sol_count !== 6'd0) begin
            n_bad++;
            $display("FAIL none_output: got valid_seen=%b cnt %0d, want 0 and 0", sv_seen, sol_count);
        end
        n_cmp++;
        if (done_cnt != 1 || done_n != 38) begin
            n_bad++;
            $display("FAIL none_done: got %0d pulses at cycle %0d, want 1 at 38", done_cnt, done_n);
        end
    endtask

    task automatic test_reset_mid();
        pq_t e;
        int  k, n;
        bit  found, extra_done;
        for (int i = 0; i < NA*NA; i++) tab[i] = 1'b0;
        tab[1*NA+1] = 1'b1;
        sol_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 60) begin
            if ({pred_p1, pred_p2} == {3'd1, 3'd3}) found = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        n_cmp++;
        if (!found || sol_count !== 6'd1 || sol_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_setup: got found=%b cnt %0d valid %b, want 1 1 1", found, sol_count, sol_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, sol_valid, pred_p1, pred_p2, sol_p1, sol_p2, sol_count} !== '0) begin
            n_bad++;
            $display("FAIL mid_async_reset: got busy=%b valid=%b pred=%0d,%0d sol=%0d,%0d cnt=%0d, want all 0",
                     busy, sol_valid, pred_p1, pred_p2, sol_p1, sol_p2, sol_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy || sol_valid) extra_done = 1;
        end
        n_cmp++;
        if (extra_done) begin
            n_bad++;
            $display("FAIL mid_no_done: got done/busy/valid after aborted sweep, want none");
        end
        set_friends();
        run_sweep(100, 1'b0, 0);
        e = exp_list();
        k = first_diff(popped_q, e);
        n_cmp++;
        if (k != -1 || pred_seq.size() == 0 || pred_seq[0] !== 6'd0) begin
            n_bad++;
            $display("FAIL mid_restart: diff at %0d, got %0d items want %0d", k, popped_q.size(), e.size());
        end
    endtask

    task automatic test_start_held();
        pq_t e;
        int  k;
        bit  idle_busy;
        set_tab(40);
        tab[0] = 1'b1;
        run_sweep(70, 1'b1, 0);
        e = exp_list();
        k = first_diff(popped_q, e);
        n_cmp++;
        if (done_cnt != 1 || k != -1) begin
            n_bad++;
            $display("FAIL held_single: got %0d dones, list diff at %0d, want 1 and none", done_cnt, k);
        end
        n_cmp++;
        if (int'(sol_count) != e.size()) begin
            n_bad++;
            $display("FAIL held_count: got %0d want %0d", sol_count, e.size());
        end
        idle_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) idle_busy = 1;
        end
        n_cmp++;
        if (idle_busy) begin
            n_bad++;
            $display("FAIL held_idle: got busy after done, want idle");
        end
        set_tab(30);
        run_sweep(100, 1'b0, 0);
        e = exp_list();
        n_cmp++;
        if (cnt_first != 0 || int'(sol_count) != e.size() || done_cnt != 1) begin
            n_bad++;
            $display("FAIL second_sweep: got first cnt %0d final %0d dones %0d, want 0 %0d 1",
                     cnt_first, sol_count, done_cnt, e.size());
        end
    endtask

    task automatic test_full_pop_push();
        pq_t e;
        int  k;
        for (int i = 0; i < NA*NA; i++) tab[i] = 1'b1;
        occ_lo = 7;
        occ_hi = 39;
        run_sweep(100, 1'b0, 6);
        occ_lo = 1;
        occ_hi = 0;
        n_cmp++;
        if (!occ_ok) begin
            n_bad++;
            $display("FAIL full_occupancy: got occupancy != %0d during pop+push cycles, want %0d", DEPTH, DEPTH);
        end
        // 36 pairs + 2 full stalls + 4 drain pops + drain-empty + done cycles
        n_cmp++;
        if (done_n != 44 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL full_timing: got done at %0d (%0d pulses), want 44 (1)", done_n, done_cnt);
        end
        e = exp_list();
        k = first_diff(popped_q, e);
        n_cmp++;
        if (k != -1 || sol_count !== 6'd36) begin
            n_bad++;
            $display("FAIL full_list: diff at %0d, got %0d items cnt %0d, want 36 items", k, popped_q.size(), sol_count);
        end
    endtask

    task automatic test_random();
        pq_t e;
        int  k, kd, pct, rp;
        for (int it = 0; it < 8; it++) begin
            pct = int'($urandom_range(90, 5));
            rp = int'($urandom_range(100, 15));
            set_tab(pct);
            run_sweep(rp, 1'b0, 0);
            e = exp_list();
            k = first_diff(popped_q, e);
            kd = first_diff(dedup(pred_seq), scan_order());
            n_cmp++;
            if (k != -1 || int'(sol_count) != e.size()) begin
                n_bad++;
                $display("FAIL rand_list[%0d]: diff at %0d, got %0d items cnt %0d want %0d",
                         it, k, popped_q.size(), sol_count, e.size());
            end
            n_cmp++;
            if (kd != -1 || done_cnt != 1 || done_n < 38 || !hold_ok || !code_ok) begin
                n_bad++;
                $display("FAIL rand_ctrl[%0d]: scan diff %0d dones %0d at %0d hold %b codes %b, want -1 1 >=38 1 1",
                         it, kd, done_cnt, done_n, hold_ok, code_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_friends();
        test_stall();
        test_none();
        test_reset_mid();
        test_start_held();
        test_full_pop_push();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
